// File: rtl/pdp8_panel_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pdp8_panel_pkg                                            |
// | Purpose  : Shared types and constants for the PDP-8/I front-panel    |
// |            key sequencer: FSM state encoding, key bit indices and    |
// |            the fixed-priority key picker.                            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package pdp8_panel_pkg;

  localparam int NUM_KEYS  = 6;

  // Key bit positions; a lower index means a higher priority.
  localparam int KEY_STOP  = 0;
  localparam int KEY_START = 1;
  localparam int KEY_CONT  = 2;
  localparam int KEY_LA    = 3;
  localparam int KEY_EX    = 4;
  localparam int KEY_DP    = 5;

  localparam logic [NUM_KEYS-1:0] STOP_MASK = NUM_KEYS'(1) << KEY_STOP;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_P0 = 3'd1,
    ST_WAIT_P1 = 3'd2,
    ST_WAIT_P2 = 3'd3,
    ST_RELEASE = 3'd4
  } panel_state_e;

  // Keep only the lowest set bit: STOP > START > CONT > LA > EX > DP.
  function automatic logic [NUM_KEYS-1:0] key_priority(input logic [NUM_KEYS-1:0] req);
    return req & (~req + NUM_KEYS'(1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/panel_key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : panel_key_debounce                                        |
// | Purpose  : One-bit key conditioner: 2-flop synchronizer followed by  |
// |            an optional stability debouncer.                          |
// | Config   : PANEL_DEBOUNCE_EN defined  -> debouncer present           |
// |            PANEL_DEBOUNCE_EN undefined -> synchronizer output only   |
// | Ports    : clk        in   system clock                              |
// |            rst        in   synchronous active-high reset             |
// |            key_raw    in   raw key level, 1 = pressed                |
// |            key_level  out  conditioned key level                     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module panel_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level
);

  // The chain resets to the "pressed" level so a key held through reset
  // keeps the sequencer parked in RELEASE instead of looking like a new press.
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PANEL_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  // r_sync1 != r_sync2 means r_sync2 changes on this edge, so the stability
  // count restarts together with the new synchronized value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_level <= 1'b1;
    end else if (r_sync1 != r_sync2) begin
      r_cnt <= '0;
    end else begin
      if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_cnt >= CNT_LAST) begin
        r_level <= r_sync2;
      end
    end
  end

  assign key_level = r_level;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (DEBOUNCE_CYCLES != 0);
  assign key_level    = r_sync2;
`endif

endmodule
`default_nettype wire

// File: rtl/panel_key_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : panel_key_sequencer                                       |
// | Purpose  : PDP-8/I console key sequencer. Conditions the operator    |
// |            keys, arbitrates presses and runs one manual-timing       |
// |            request per accepted press, framed by MFTP0/1/2.          |
// | Config   : PANEL_DEBOUNCE_EN enables the per-key debouncer.          |
// | Ports    : clk, rst          clock, synchronous active-high reset    |
// |            keys_raw[5:0]     STOP,START,CONT,LA,EX,DP (bit 0..5)     |
// |            run               processor RUN flip-flop                 |
// |            mftp0/1/2         manual timing pulses from generator     |
// |            mfts_req          manual timing start request             |
// |            func[5:0]         one-hot active key function             |
// |            busy              manual sequence in progress             |
// |            stop_req          one-cycle STOP pulse                    |
// |            seq_done          one-cycle sequence-complete pulse       |
// |            err_timeout       sticky MFTP timeout flag                |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module panel_key_sequencer
  import pdp8_panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys_raw,
  input  logic                run,
  input  logic                mftp0,
  input  logic                mftp1,
  input  logic                mftp2,
  output logic                mfts_req,
  output logic [NUM_KEYS-1:0] func,
  output logic                busy,
  output logic                stop_req,
  output logic                seq_done,
  output logic                err_timeout
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_HIT = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [NUM_KEYS-1:0] w_level;
  logic [NUM_KEYS-1:0] r_level_q;
  logic [NUM_KEYS-1:0] r_press;
  logic [NUM_KEYS-1:0] w_accept;
  logic [NUM_KEYS-1:0] w_pick;
  logic                r_mftp0_q, r_mftp1_q, r_mftp2_q;
  logic                w_rise0, w_rise1, w_rise2;
  logic                w_tmo_hit;

  panel_state_e        r_state;
  logic [TMO_W-1:0]    r_tmo;
  logic                r_mfts_req;
  logic [NUM_KEYS-1:0] r_func;
  logic                r_stop_req;
  logic                r_seq_done;
  logic                r_err_timeout;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    panel_key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .rst      (rst),
      .key_raw  (keys_raw[gi]),
      .key_level(w_level[gi])
    );
  end

  // Registered rising-edge detect; the previous level resets high to match
  // the conditioner's post-reset "pressed" level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level_q <= '1;
      r_press   <= '0;
      r_mftp0_q <= 1'b0;
      r_mftp1_q <= 1'b0;
      r_mftp2_q <= 1'b0;
    end else begin
      r_level_q <= w_level;
      r_press   <= w_level & ~r_level_q;
      r_mftp0_q <= mftp0;
      r_mftp1_q <= mftp1;
      r_mftp2_q <= mftp2;
    end
  end

  assign w_rise0   = mftp0 & ~r_mftp0_q;
  assign w_rise1   = mftp1 & ~r_mftp1_q;
  assign w_rise2   = mftp2 & ~r_mftp2_q;
  assign w_accept  = run ? (r_press & STOP_MASK) : r_press;
  assign w_pick    = key_priority(w_accept);
  assign w_tmo_hit = (r_tmo == TMO_HIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RELEASE;
      r_tmo         <= '0;
      r_mfts_req    <= 1'b0;
      r_func        <= '0;
      r_stop_req    <= 1'b0;
      r_seq_done    <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_stop_req <= 1'b0;
      r_seq_done <= 1'b0;
      if (r_tmo != TMO_MAX) begin
        r_tmo <= r_tmo + TMO_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (|w_accept) begin
            r_tmo <= '0;
            if (w_pick[KEY_STOP]) begin
              r_stop_req <= 1'b1;
              r_state    <= ST_RELEASE;
            end else begin
              r_func     <= w_pick;
              r_mfts_req <= 1'b1;
              r_state    <= ST_WAIT_P0;
            end
          end
        end

        ST_WAIT_P0, ST_WAIT_P1, ST_WAIT_P2: begin
          if (r_state == ST_WAIT_P0 && w_rise0) begin
            r_mfts_req <= 1'b0;
            r_tmo      <= '0;
            r_state    <= ST_WAIT_P1;
          end else if (r_state == ST_WAIT_P1 && w_rise1) begin
            r_tmo   <= '0;
            r_state <= ST_WAIT_P2;
          end else if (r_state == ST_WAIT_P2 && w_rise2) begin
            // func is cleared one cycle later in RELEASE so it stays
            // valid alongside seq_done.
            r_seq_done <= 1'b1;
            r_tmo      <= '0;
            r_state    <= ST_RELEASE;
          end else if (w_tmo_hit) begin
            r_err_timeout <= 1'b1;
            r_mfts_req    <= 1'b0;
            r_func        <= '0;
            r_tmo         <= '0;
            r_state       <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          r_func <= '0;
          if (~|w_level) begin
            r_tmo   <= '0;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_RELEASE;
        end
      endcase
    end
  end

  assign mfts_req    = r_mfts_req;
  assign func        = r_func;
  assign busy        = (r_state == ST_WAIT_P0) || (r_state == ST_WAIT_P1) ||
                       (r_state == ST_WAIT_P2);
  assign stop_req    = r_stop_req;
  assign seq_done    = r_seq_done;
  assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_panel_key_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_panel_key_sequencer                                    |
// | Purpose  : Directed self-checking bench for panel_key_sequencer with |
// |            a manual timing generator model.                          |
// | Config   : honours PANEL_DEBOUNCE_EN (changes press latency).        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_panel_key_sequencer;

  localparam int DEB = 4;
  localparam int TMO = 32;
`ifdef PANEL_DEBOUNCE_EN
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif

  localparam logic [5:0] K_STOP  = 6'b000001;
  localparam logic [5:0] K_START = 6'b000010;
  localparam logic [5:0] K_LA    = 6'b001000;
  localparam logic [5:0] K_EX    = 6'b010000;
  localparam logic [5:0] K_DP    = 6'b100000;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic [5:0] keys_raw = 6'b0;
  logic       run      = 1'b0;
  logic       mftp0    = 1'b0;
  logic       mftp1    = 1'b0;
  logic       mftp2    = 1'b0;
  logic       skip_p1  = 1'b0;
  logic       mfts_req, busy, stop_req, seq_done, err_timeout;
  logic [5:0] func;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int req_rise_cnt = 0;
  int stop_cnt     = 0;
  int sd_cnt       = 0;
  int busy_cnt     = 0;
  logic req_q      = 1'b0;

  always #5 clk = ~clk;

  panel_key_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .keys_raw   (keys_raw),
    .run        (run),
    .mftp0      (mftp0),
    .mftp1      (mftp1),
    .mftp2      (mftp2),
    .mfts_req   (mfts_req),
    .func       (func),
    .busy       (busy),
    .stop_req   (stop_req),
    .seq_done   (seq_done),
    .err_timeout(err_timeout)
  );

  // Event counters sampled on the active edge (pre-update values).
  always @(posedge clk) begin
    if (mfts_req === 1'b1 && req_q !== 1'b1) req_rise_cnt <= req_rise_cnt + 1;
    req_q <= mfts_req;
    if (stop_req === 1'b1) stop_cnt <= stop_cnt + 1;
    if (seq_done === 1'b1) sd_cnt <= sd_cnt + 1;
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  // Generator model: MFTP0/1/2 at +1/+11/+21 cycles after the request edge,
  // each 3 cycles wide; the gaps sit well inside TIMEOUT_CYCLES.
  initial begin
    forever begin
      @(posedge mfts_req);
      @(posedge clk); #1 mftp0 = 1'b1;
      repeat (3) @(posedge clk); #1 mftp0 = 1'b0;
      repeat (7) @(posedge clk); #1 mftp1 = !skip_p1;
      repeat (3) @(posedge clk); #1 mftp1 = 1'b0;
      repeat (7) @(posedge clk); #1 mftp2 = 1'b1;
      repeat (3) @(posedge clk); #1 mftp2 = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive a key pattern on a negedge and check the request appears on time.
  task automatic press_req(input string tag, input logic [5:0] k, input logic [5:0] exp_func);
    keys_raw = k;
    repeat (LAT) @(negedge clk);
    chk({tag, "_req_early"}, mfts_req, 1'b0);
    @(negedge clk);
    chk({tag, "_req"},  mfts_req, 1'b1);
    chk({tag, "_func"}, func, exp_func);
    chk({tag, "_busy"}, busy, 1'b1);
  endtask

  // Follow a running sequence to seq_done and check its framing.
  task automatic run_seq(input string tag, input logic [5:0] exp_func);
    int p0 = -1;
    int rf = -1;
    int p2 = -1;
    int sd = -1;
    logic m0q, m2q, rq;
    logic [5:0] f_sd;
    f_sd = '0;
    m0q = mftp0;
    m2q = mftp2;
    rq  = mfts_req;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (p0 < 0 && mftp0 && !m0q) p0 = i;
      if (rf < 0 && !mfts_req && rq) rf = i;
      if (p2 < 0 && mftp2 && !m2q) p2 = i;
      m0q = mftp0;
      m2q = mftp2;
      rq  = mfts_req;
      if (seq_done) begin
        sd   = i;
        f_sd = func;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(sd >= 0), 1);
    chk({tag, "_req_fall_lat"}, rf - p0, 1);
    chk({tag, "_sd_lat"}, sd - p2, 1);
    chk({tag, "_func_at_sd"}, f_sd, exp_func);
    @(negedge clk);
    chk({tag, "_sd_one_cycle"}, seq_done, 1'b0);
    chk({tag, "_func_cleared"}, func, 6'b0);
    chk({tag, "_busy_cleared"}, busy, 1'b0);
  endtask

  initial begin
    int s_req, s_sd, s_stop, s_busy;
    bit found;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    chk("rst_mfts_req", mfts_req, 1'b0);
    chk("rst_func", func, 6'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_stop_req", stop_req, 1'b0);
    chk("rst_seq_done", seq_done, 1'b0);
    chk("rst_err", err_timeout, 1'b0);
    rst = 1'b0;
    repeat (15) @(negedge clk);

    // ---------------- LA press, run=0 ----------------
    s_req = req_rise_cnt;
    s_sd  = sd_cnt;
    press_req("la", K_LA, K_LA);
    run_seq("la", K_LA);
    repeat (20) @(negedge clk);
    chk("la_single_req", req_rise_cnt - s_req, 1);
    chk("la_single_done", sd_cnt - s_sd, 1);
    keys_raw = 6'b0;
    repeat (15) @(negedge clk);

    // ---------------- EX + DP together ----------------
    s_req = req_rise_cnt;
    press_req("exdp", K_EX | K_DP, K_EX);
    run_seq("exdp", K_EX);
    keys_raw = K_DP;
    repeat (30) @(negedge clk);
    chk("exdp_dp_ignored", req_rise_cnt - s_req, 1);
    keys_raw = 6'b0;
    repeat (15) @(negedge clk);
    press_req("dp", K_DP, K_DP);
    run_seq("dp", K_DP);
    keys_raw = 6'b0;
    repeat (15) @(negedge clk);

    // ---------------- run=1: START then STOP ----------------
    s_req  = req_rise_cnt;
    s_stop = stop_cnt;
    s_busy = busy_cnt;
    run      = 1'b1;
    keys_raw = K_START;
    repeat (LAT + 3) @(negedge clk);
    chk("run_start_no_req", mfts_req, 1'b0);
    keys_raw = K_START | K_STOP;
    repeat (LAT) @(negedge clk);
    chk("run_stop_early", stop_req, 1'b0);
    @(negedge clk);
    chk("run_stop_pulse", stop_req, 1'b1);
    @(negedge clk);
    chk("run_stop_one_cycle", stop_req, 1'b0);
    repeat (10) @(negedge clk);
    chk("run_stop_count", stop_cnt - s_stop, 1);
    chk("run_req_count", req_rise_cnt - s_req, 0);
    chk("run_busy_never", busy_cnt - s_busy, 0);
    keys_raw = 6'b0;
    run      = 1'b0;
    repeat (15) @(negedge clk);

    // ---------------- bounce then hold ----------------
    s_req = req_rise_cnt;
    s_sd  = sd_cnt;
    for (int t = 0; t < 10; t++) begin
      keys_raw = keys_raw ^ K_LA;
      repeat (2) @(negedge clk);
    end
    keys_raw = K_LA;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (sd_cnt != s_sd) found = 1'b1;
    end
    repeat (20) @(negedge clk);
    chk("bounce_done_seen", 32'(found), 1);
    chk("bounce_single_req", req_rise_cnt - s_req, 1);
    chk("bounce_single_done", sd_cnt - s_sd, 1);
    keys_raw = 6'b0;
    repeat (15) @(negedge clk);

    // ---------------- MFTP1 suppressed: timeout ----------------
    s_sd    = sd_cnt;
    skip_p1 = 1'b1;
    press_req("tmo", K_LA, K_LA);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (!mfts_req) found = 1'b1;
    end
    chk("tmo_req_fell", 32'(found), 1);
    // Now one negedge past WAIT_P1 entry.
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_err_early", err_timeout, 1'b0);
    @(negedge clk);
    chk("tmo_err_set", err_timeout, 1'b1);
    chk("tmo_func_clr", func, 6'b0);
    chk("tmo_busy_clr", busy, 1'b0);
    repeat (30) @(negedge clk);
    chk("tmo_no_done", sd_cnt - s_sd, 0);
    keys_raw = 6'b0;
    skip_p1  = 1'b0;
    repeat (15) @(negedge clk);
    chk("tmo_err_sticky", err_timeout, 1'b1);

    // ---------------- reset in WAIT_P2 with key held ----------------
    press_req("rstp2", K_LA, K_LA);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (mftp1) found = 1'b1;
    end
    chk("rstp2_p1_seen", 32'(found), 1);
    @(negedge clk);
    chk("rstp2_in_p2_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstp2_outputs_zero",
        {26'b0, mfts_req, busy, stop_req, seq_done, err_timeout, |func}, 32'b0);
    @(negedge clk);
    rst   = 1'b0;
    s_req = req_rise_cnt;
    repeat (40) @(negedge clk);
    chk("rstp2_held_no_req", req_rise_cnt - s_req, 0);
    chk("rstp2_held_idle", busy, 1'b0);
    keys_raw = 6'b0;
    repeat (15) @(negedge clk);
    press_req("repress", K_LA, K_LA);
    run_seq("repress", K_LA);
    keys_raw = 6'b0;
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
`default_nettype wire
